// File: rtl/apple_manager.sv
// Apple (food) cell owner for the snake game: detects the head eating the
// apple and relocates it to a pseudo-random free cell, checked against a full segment pass.
// Latency: o_eat one cycle after the matching head beat; new apple appears on the tail beat's next cycle.
// Backpressure: none; segment beats are consumed as they come, i_halt freezes everything and drops beats.

module apple_manager #(
  parameter int unsigned GAME_WIDTH  = 30,
  parameter int unsigned GAME_HEIGHT = 14,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned APPLE_X0    = 20,
  parameter int unsigned APPLE_Y0    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_halt,
  input  logic       i_entropy,
  output logic       o_eat,
  output logic [4:0] o_apple_x,
  output logic [3:0] o_apple_y,
  output logic       o_apple_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHOOSE = 2'd1,
    S_WAIT   = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Latched relocation candidate and its collision flag for the current pass.
  logic [4:0]  cand_x;
  logic [3:0]  cand_y;
  logic        coll;

  // Candidate drawn from the current LFSR value.
  logic [4:0]  draw_x;
  logic [3:0]  draw_y;
  logic        draw_legal;

  // Segment compare results for this cycle.
  logic        head_on_apple;
  logic        seg_on_cand;
  logic        hit_now;
  logic        pass_beat;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), with user entropy stirred in.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10] ^ i_entropy;

  assign draw_x = lfsr[4:0];
  assign draw_y = lfsr[8:5];

  // Walls sit at 0 and at WIDTH+1 / HEIGHT+1; compare at full width so no wrap can sneak a wall in.
  assign draw_legal = (draw_x != 5'd0) && (32'(draw_x) <= GAME_WIDTH) &&
                      (draw_y != 4'd0) && (32'(draw_y) <= GAME_HEIGHT);

  assign head_on_apple = (i_pos_x == o_apple_x) && (i_pos_y == o_apple_y);
  assign seg_on_cand   = (i_pos_x == cand_x) && (i_pos_y == cand_y);

  // A head beat starts a fresh pass (also recovers from a missed tail); other beats accumulate.
  assign hit_now = (state == S_CHECK && !i_pos_first) ? (coll | seg_on_cand) : seg_on_cand;

  // Beats that belong to the pass being validated: the head while waiting, anything while checking.
  assign pass_beat = i_pos_valid && (i_pos_first || state == S_CHECK);

  // LFSR: free-running unless halted; a lock-up at zero is broken by reloading the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (!i_halt) begin
      if (lfsr == 16'd0) begin
        lfsr <= SEED;
      end else begin
        lfsr <= {lfsr[14:0], lfsr_fb};
      end
    end
  end

  // Apple FSM: eat detection, candidate draw, and pass-wide collision check with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      o_apple_x     <= 5'(APPLE_X0);
      o_apple_y     <= 4'(APPLE_Y0);
      o_apple_valid <= 1'b1;
      o_eat         <= 1'b0;
      cand_x        <= 5'd0;
      cand_y        <= 4'd0;
      coll          <= 1'b0;
    end else if (i_halt) begin
      o_eat <= 1'b0;
    end else begin
      o_eat <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Only the head can eat; body segments over the apple are ignored.
          if (i_pos_valid && i_pos_first && head_on_apple) begin
            o_eat         <= 1'b1;
            o_apple_valid <= 1'b0;
            state         <= S_CHOOSE;
          end
        end
        S_CHOOSE: begin
          // Illegal draws simply retry on the next LFSR value.
          if (draw_legal) begin
            cand_x <= draw_x;
            cand_y <= draw_y;
            coll   <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT, S_CHECK: begin
          if (pass_beat) begin
            coll <= hit_now;
            if (i_pos_last) begin
              if (hit_now) begin
                state <= S_CHOOSE;
              end else begin
                o_apple_x     <= cand_x;
                o_apple_y     <= cand_y;
                o_apple_valid <= 1'b1;
                state         <= S_IDLE;
              end
            end else begin
              state <= S_CHECK;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apple_manager.sv
// Scoreboard bench for apple_manager: a per-cycle reference model predicts the outputs,
// a monitor compares them on the falling edge, directed scenarios steer the LFSR via i_entropy.
`timescale 1ns/1ps

module tb_apple_manager;

  localparam int SEED_V = 16'hACE1;

  logic       clk;
  logic       rst;
  logic [4:0] pos_x;
  logic [3:0] pos_y;
  logic       pos_first;
  logic       pos_last;
  logic       pos_valid;
  logic       halt;
  logic       entropy;
  logic       eat;
  logic [4:0] apple_x;
  logic [3:0] apple_y;
  logic       apple_valid;

  apple_manager dut (
    .clk          (clk),
    .rst          (rst),
    .i_pos_x      (pos_x),
    .i_pos_y      (pos_y),
    .i_pos_first  (pos_first),
    .i_pos_last   (pos_last),
    .i_pos_valid  (pos_valid),
    .i_halt       (halt),
    .i_entropy    (entropy),
    .o_eat        (eat),
    .o_apple_x    (apple_x),
    .o_apple_y    (apple_y),
    .o_apple_valid(apple_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       eat;
    logic [4:0] ax;
    logic [3:0] ay;
    logic       av;
  } exp_t;

  exp_t sb_q[$];
  bit   steer_q[$];
  bit   mon_en;
  int   checks;
  int   errors;

  // Reference model: game-level view (is the apple being moved, do we hold a candidate,
  // has the current pass started, has any segment touched the candidate).
  int   m_lfsr;
  int   m_ax, m_ay, m_cx, m_cy;
  bit   m_av, m_eat, m_reloc, m_have, m_inpass, m_hit;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // One clock of stimulus; the model predicts the outputs visible after this edge.
  task automatic step(input bit v, input logic [4:0] x, input logic [3:0] y,
                      input bit f, input bit l, input bit h);
    int  fb, ent, kx, ky;
    bit  d;
    exp_t e;
    fb  = ^(m_lfsr & 32'hB400);
    ent = int'($urandom_range(0, 1));
    if (!h && m_lfsr != 0 && steer_q.size() > 0) begin
      d   = steer_q.pop_front();
      ent = int'(d) ^ fb;
    end
    pos_valid = v; pos_x = x; pos_y = y; pos_first = f; pos_last = l;
    halt = h; entropy = ent[0];
    if (h) begin
      m_eat = 1'b0;
    end else begin
      m_eat = 1'b0;
      kx = m_lfsr % 32;
      ky = (m_lfsr / 32) % 16;
      if (!m_reloc) begin
        if (v && f && int'(x) == m_ax && int'(y) == m_ay) begin
          m_eat = 1'b1; m_av = 1'b0; m_reloc = 1'b1; m_have = 1'b0;
        end
      end else if (!m_have) begin
        if (kx >= 1 && kx <= 30 && ky >= 1 && ky <= 14) begin
          m_cx = kx; m_cy = ky; m_have = 1'b1; m_inpass = 1'b0; m_hit = 1'b0;
        end
      end else if (v && (f || m_inpass)) begin
        m_hit    = (f ? 1'b0 : m_hit) | (int'(x) == m_cx && int'(y) == m_cy);
        m_inpass = 1'b1;
        if (l) begin
          if (m_hit) begin
            m_have = 1'b0;
          end else begin
            m_ax = m_cx; m_ay = m_cy; m_av = 1'b1; m_reloc = 1'b0;
          end
        end
      end
      if (m_lfsr == 0) m_lfsr = SEED_V;
      else             m_lfsr = ((m_lfsr * 2) % 65536) + (fb ^ ent);
    end
    e = '{m_eat, 5'(m_ax), 4'(m_ay), m_av};
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    sb_q.delete();
    steer_q.delete();
    pos_valid = 0; pos_x = 0; pos_y = 0; pos_first = 0; pos_last = 0;
    halt = 0; entropy = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_apple_x", apple_x, 20);
    chk("rst_apple_y", apple_y, 8);
    chk("rst_apple_valid", apple_valid, 1);
    chk("rst_eat", eat, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    m_lfsr = SEED_V; m_ax = 20; m_ay = 8; m_av = 1'b1; m_eat = 1'b0;
    m_reloc = 1'b0; m_have = 1'b0; m_inpass = 1'b0; m_hit = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic random_pass(input bit allow_halt, input bit aim);
    int len, px, py;
    bit lst, hh;
    len = int'($urandom_range(1, 5));
    for (int i = 0; i < len; i++) begin
      px = int'($urandom_range(1, 30));
      py = int'($urandom_range(1, 14));
      if (aim && !m_reloc && $urandom_range(0, 2) == 0) begin
        px = m_ax; py = m_ay;
      end else if (m_have && $urandom_range(0, 5) == 0) begin
        px = m_cx; py = m_cy;
      end
      lst = (i == len - 1) && ($urandom_range(0, 7) != 0);
      hh  = allow_halt && ($urandom_range(0, 15) == 0);
      step(1'b1, 5'(px), 4'(py), i == 0, lst, hh);
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             allow_halt && ($urandom_range(0, 15) == 0));
    end
  endtask

  // Monitor: every clock the DUT presents a full output set; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (eat !== e.eat || apple_x !== e.ax || apple_y !== e.ay || apple_valid !== e.av) begin
        errors++;
        $display("FAIL outputs @%0t: got eat=%0d x=%0d y=%0d vld=%0d, want eat=%0d x=%0d y=%0d vld=%0d",
                 $time, eat, apple_x, apple_y, apple_valid, e.eat, e.ax, e.ay, e.av);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sx, sy, n;
    checks = 0; errors = 0; mon_en = 1'b0;
    rst = 1'b0;
    pos_valid = 0; pos_x = 0; pos_y = 0; pos_first = 0; pos_last = 0;
    halt = 0; entropy = 0;
    do_reset();

    // Body segments over the apple never eat.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd20, 4'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd20, 4'd8, 1'b0, 1'b1, 1'b0);
    chk("body_no_eat", eat, 0);
    chk("body_apple_x", apple_x, 20);

    // Steer draws: (0,0) illegal, x=1,3,7,15,31 with y=0 illegal, then (30,1) legal.
    repeat (7) steer_q.push_back(1'b1);
    repeat (9) steer_q.push_back(1'b0);
    idle(15);
    step(1'b1, 5'd20, 4'd8, 1'b1, 1'b0, 1'b0);
    chk("eat_pulse", eat, 1);
    chk("eat_valid_low", apple_valid, 0);
    for (int i = 0; i < 5; i++) steer_q.push_back(1'b1);
    steer_q.push_back(1'b0);
    step(1'b1, 5'd21, 4'd8, 1'b0, 1'b1, 1'b0);
    chk("eat_one_cycle", eat, 0);
    idle(6);
    chk("choose_hold_valid", apple_valid, 0);
    chk("choose_hold_x", apple_x, 20);
    // Head on the old apple cell during validation: no second eat.
    step(1'b1, 5'd20, 4'd8, 1'b1, 1'b0, 1'b0);
    chk("no_reeat", eat, 0);
    step(1'b1, 5'd10, 4'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd12, 4'd5, 1'b0, 1'b1, 1'b0);
    chk("commit_x", apple_x, 30);
    chk("commit_y", apple_y, 1);
    chk("commit_valid", apple_valid, 1);

    // Candidate (5,3) collides with the tail: must go back and choose again.
    repeat (7) steer_q.push_back(1'b1);
    foreach (steer_q[i]) ;
    begin
      bit pat[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) steer_q.push_back(pat[i]);
    end
    idle(15);
    step(1'b1, 5'd30, 4'd1, 1'b1, 1'b0, 1'b0);
    chk("eat2_pulse", eat, 1);
    idle(1);
    step(1'b1, 5'd7, 4'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 5'd8, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 5'd5, 4'd3, 1'b0, 1'b1, 1'b0);
    chk("coll_valid_low", apple_valid, 0);
    chk("coll_hold_x", apple_x, 30);
    chk("coll_hold_y", apple_y, 1);
    n = 0;
    while (m_reloc && n < 300) begin random_pass(1'b0, 1'b0); n++; end
    if (m_reloc) bound_fail("coll_recover");
    chk("recover_valid", apple_valid, 1);

    // Halt for 50 cycles in the middle of a check pass.
    step(1'b1, 5'(m_ax), 4'(m_ay), 1'b1, 1'b0, 1'b0);
    chk("eat3_pulse", eat, 1);
    n = 0;
    while (!m_have && n < 200) begin idle(1); n++; end
    if (!m_have) bound_fail("halt_choose");
    sx = m_ax; sy = m_ay;
    step(1'b1, 5'($urandom_range(1, 30)), 4'($urandom_range(1, 14)), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      step(1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    chk("halt_eat", eat, 0);
    chk("halt_valid", apple_valid, 0);
    chk("halt_apple_x", apple_x, sx);
    chk("halt_apple_y", apple_y, sy);
    n = 0;
    while (m_reloc && n < 300) begin random_pass(1'b0, 1'b0); n++; end
    if (m_reloc) bound_fail("halt_recover");

    // Reset in the middle of a relocation restores the power-on apple.
    step(1'b1, 5'(m_ax), 4'(m_ay), 1'b1, 1'b0, 1'b0);
    idle(2);
    do_reset();

    // Random traffic with halts, truncated passes and garbage on invalid cycles.
    for (int i = 0; i < 400; i++) random_pass(1'b1, 1'b1);
    idle(2);
    @(negedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
